// File: rtl/warp_scheduler.sv
// Warp scheduler: splits one thread block into warps and issues READY warps round-robin.
// Latency: start -> INIT -> first offer in the first RUN cycle; wb/exit -> warp reissuable next cycle.
// Backpressure: a pending offer (issue_valid & !issue_ready) is held with stable id/mask until taken.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   start/block_id/block_dim dispatcher request, sampled only in IDLE
//   done/busy/cfg_err        completion pulse, non-IDLE flag, sticky oversize-block flag
//   issue_*                  valid/ready offer of one warp (id, thread mask, block id)
//   wb_*/exit_*              per-warp instruction writeback and EXIT notifications
// Optional build macro SCHED_PERF_EN adds perf_issued / perf_stall saturating counters.
module warp_scheduler #(
    parameter int NUM_WARPS = 8,
    parameter int WARP_SIZE = 32,
    parameter int WID_W     = $clog2(NUM_WARPS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [31:0]          block_id,
    input  logic [31:0]          block_dim,
    output logic                 done,
    output logic                 busy,
    output logic                 cfg_err,
    output logic                 issue_valid,
    input  logic                 issue_ready,
    output logic [WID_W-1:0]     issue_warp_id,
    output logic [WARP_SIZE-1:0] issue_mask,
    output logic [31:0]          issue_block_id,
    input  logic                 wb_valid,
    input  logic [WID_W-1:0]     wb_warp_id,
    input  logic                 exit_valid,
    input  logic [WID_W-1:0]     exit_warp_id
`ifdef SCHED_PERF_EN
    ,
    output logic [31:0]          perf_issued,
    output logic [31:0]          perf_stall
`endif
);

    localparam int LOG_WS = $clog2(WARP_SIZE);

    typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN, S_DONE} state_t;
    typedef enum logic [1:0] {W_INACTIVE, W_READY, W_BUSY, W_EXITED} wstate_t;

    state_t           state;
    wstate_t          ws      [NUM_WARPS];
    wstate_t          ws_next [NUM_WARPS];
    logic [WID_W-1:0] rr_ptr;
    logic [31:0]      blk_dim;

    logic [LOG_WS-1:0]    rem;
    logic [31:0]          warps_raw;
    logic                 clamp;
    logic [WID_W:0]       nw;
    logic [WARP_SIZE-1:0] last_mask;
    logic                 hs;
    logic [WID_W-1:0]     scan_base;
    logic                 found;
    logic [WID_W-1:0]     found_id;
    logic                 all_exited;
    logic                 hold;
    logic                 offering;

    // Warp count derived from the captured block size. Computed as quotient plus
    // a remainder carry so huge block_dim values cannot overflow the 32-bit sum.
    always_comb begin
        rem       = blk_dim[LOG_WS-1:0];
        warps_raw = (blk_dim >> LOG_WS) + 32'(rem != '0);
        clamp     = warps_raw > 32'(NUM_WARPS);
        nw        = clamp ? (WID_W+1)'(NUM_WARPS) : warps_raw[WID_W:0];
        last_mask = (clamp || rem == '0) ? '1 : ((WARP_SIZE'(1) << rem) - WARP_SIZE'(1));
    end

    assign hs   = issue_valid & issue_ready;
    assign hold = issue_valid & ~issue_ready;

    // Next per-warp state. wb/exit only act on BUSY warps, so they never collide
    // with the handshake, which always targets a READY warp.
    always_comb begin
        all_exited = 1'b1;
        for (int i = 0; i < NUM_WARPS; i++) begin
            ws_next[i] = ws[i];
            if (state == S_INIT) begin
                ws_next[i] = ((WID_W+1)'(i) < nw) ? W_READY : W_INACTIVE;
            end else if (state == S_RUN) begin
                if (ws[i] == W_BUSY) begin
                    if (exit_valid && exit_warp_id == WID_W'(i))
                        ws_next[i] = W_EXITED;
                    else if (wb_valid && wb_warp_id == WID_W'(i))
                        ws_next[i] = W_READY;
                end else if (ws[i] == W_READY && hs && issue_warp_id == WID_W'(i)) begin
                    ws_next[i] = W_BUSY;
                end
            end
            if (ws_next[i] == W_READY || ws_next[i] == W_BUSY)
                all_exited = 1'b0;
        end
    end

    // Round-robin scan over next-cycle states, starting just after the warp that
    // wins this cycle's handshake (or the stored pointer when nothing issues).
    always_comb begin
        int               idx;
        logic [WID_W-1:0] widx;
        scan_base = hs ? issue_warp_id : rr_ptr;
        found     = 1'b0;
        found_id  = '0;
        idx       = 0;
        widx      = '0;
        for (int k = 1; k <= NUM_WARPS; k++) begin
            idx = int'(scan_base) + k;
            if (idx >= NUM_WARPS)
                idx = idx - NUM_WARPS;
            widx = WID_W'(idx);
            if (!found && ws_next[widx] == W_READY) begin
                found    = 1'b1;
                found_id = widx;
            end
        end
    end

    // An offer can exist next cycle only while the block stays in RUN.
    assign offering = (state == S_INIT && nw != '0) || (state == S_RUN && !all_exited);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            for (int i = 0; i < NUM_WARPS; i++)
                ws[i] <= W_INACTIVE;
            rr_ptr         <= WID_W'(NUM_WARPS - 1);
            blk_dim        <= '0;
            issue_block_id <= '0;
            cfg_err        <= 1'b0;
            done           <= 1'b0;
            busy           <= 1'b0;
            issue_valid    <= 1'b0;
            issue_warp_id  <= '0;
            issue_mask     <= '0;
        end else begin
            done <= 1'b0;
            for (int i = 0; i < NUM_WARPS; i++)
                ws[i] <= ws_next[i];
            if (hs)
                rr_ptr <= issue_warp_id;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state          <= S_INIT;
                        busy           <= 1'b1;
                        issue_block_id <= block_id;
                        blk_dim        <= block_dim;
                        cfg_err        <= 1'b0;
                    end
                end
                S_INIT: begin
                    cfg_err <= clamp;
                    if (nw == '0) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (all_exited) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase

            if (offering) begin
                if (!hold) begin
                    issue_valid   <= found;
                    issue_warp_id <= found ? found_id : '0;
                    if (!found)
                        issue_mask <= '0;
                    else if ({1'b0, found_id} == nw - (WID_W+1)'(1))
                        issue_mask <= last_mask;
                    else
                        issue_mask <= '1;
                end
            end else begin
                issue_valid   <= 1'b0;
                issue_warp_id <= '0;
                issue_mask    <= '0;
            end
        end
    end

`ifdef SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (rst || (state == S_IDLE && start)) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            if (hs && perf_issued != '1)
                perf_issued <= perf_issued + 32'd1;
            if (state == S_RUN && !hs && perf_stall != '1)
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_warp_scheduler.sv
// Randomized bench for warp_scheduler against a thread-counting behavioural model.
// Outputs are compared every cycle, 1 time unit after the rising edge.
// Inputs are driven right after the compare and held until the next edge.
module tb_warp_scheduler;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] block_id;
    logic [31:0] block_dim;
    logic        done;
    logic        busy;
    logic        cfg_err;
    logic        issue_valid;
    logic        issue_ready;
    logic [2:0]  issue_warp_id;
    logic [31:0] issue_mask;
    logic [31:0] issue_block_id;
    logic        wb_valid;
    logic [2:0]  wb_warp_id;
    logic        exit_valid;
    logic [2:0]  exit_warp_id;

    warp_scheduler dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .block_id       (block_id),
        .block_dim      (block_dim),
        .done           (done),
        .busy           (busy),
        .cfg_err        (cfg_err),
        .issue_valid    (issue_valid),
        .issue_ready    (issue_ready),
        .issue_warp_id  (issue_warp_id),
        .issue_mask     (issue_mask),
        .issue_block_id (issue_block_id),
        .wb_valid       (wb_valid),
        .wb_warp_id     (wb_warp_id),
        .exit_valid     (exit_valid),
        .exit_warp_id   (exit_warp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    endtask

    // Reference model. Phases: 0 idle, 1 init, 2 run, 3 done.
    // Warp states: 0 inactive, 1 ready, 2 busy, 3 exited.
    int          m_phase;
    int          m_ws [8];
    int          m_rr;
    bit          m_vld;
    int          m_id;
    longint      m_dim;
    bit [31:0]   m_blk;
    bit          m_err;
    bit          m_done;

    function automatic logic [31:0] exp_mask(input int w);
        longint      cnt;
        logic [63:0] t;
        cnt = m_dim - longint'(w) * 32;
        if (cnt >= 32)
            return 32'hFFFF_FFFF;
        t = (64'd1 << cnt) - 64'd1;
        return t[31:0];
    endfunction

    task automatic pick_offer();
        int w;
        m_vld = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            w = (m_rr + k) % 8;
            if (!m_vld && m_ws[w] == 1) begin
                m_vld = 1'b1;
                m_id  = w;
            end
        end
    endtask

    task automatic model_step();
        bit hs;
        bit live;
        int nw;
        if (rst) begin
            m_phase = 0;
            for (int i = 0; i < 8; i++) m_ws[i] = 0;
            m_rr = 7; m_vld = 0; m_id = 0; m_dim = 0; m_blk = 0; m_err = 0; m_done = 0;
        end else begin
            hs     = m_vld && issue_ready;
            m_done = 0;
            case (m_phase)
                0: if (start) begin
                    m_phase = 1;
                    m_dim   = longint'(block_dim);
                    m_blk   = block_id;
                    m_err   = 0;
                end
                1: begin
                    nw    = int'((m_dim + 31) / 32);
                    m_err = nw > 8;
                    if (nw > 8) nw = 8;
                    for (int i = 0; i < 8; i++) m_ws[i] = (i < nw) ? 1 : 0;
                    if (nw == 0) begin
                        m_phase = 3;
                        m_done  = 1;
                    end else begin
                        m_phase = 2;
                        pick_offer();
                    end
                end
                2: begin
                    // exit is applied first so a same-cycle wb finds the warp no longer busy
                    if (exit_valid && m_ws[exit_warp_id] == 2) m_ws[exit_warp_id] = 3;
                    if (wb_valid && m_ws[wb_warp_id] == 2) m_ws[wb_warp_id] = 1;
                    if (hs) begin
                        m_ws[m_id] = 2;
                        m_rr       = m_id;
                    end
                    live = 0;
                    for (int i = 0; i < 8; i++) if (m_ws[i] == 1 || m_ws[i] == 2) live = 1;
                    if (!live) begin
                        m_phase = 3;
                        m_done  = 1;
                        m_vld   = 0;
                    end else if (!(m_vld && !issue_ready)) begin
                        pick_offer();
                    end
                end
                default: m_phase = 0;
            endcase
        end
    endtask

    task automatic compare_all();
        chk("issue_valid", issue_valid, m_vld);
        if (m_vld) begin
            chk("issue_warp_id", issue_warp_id, m_id);
            chk("issue_mask", issue_mask, exp_mask(m_id));
        end
        chk("done", done, m_done);
        chk("busy", busy, m_phase != 0);
        chk("cfg_err", cfg_err, m_err);
        chk("issue_block_id", issue_block_id, m_blk);
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic quiet_inputs();
        start = 0; block_id = 0; block_dim = 0; issue_ready = 0;
        wb_valid = 0; wb_warp_id = 0; exit_valid = 0; exit_warp_id = 0;
    endtask

    task automatic rand_inputs();
        int busy_list [8];
        int nb;
        nb = 0;
        for (int i = 0; i < 8; i++) if (m_ws[i] == 2) begin busy_list[nb] = i; nb++; end
        issue_ready = ($urandom_range(0, 3) != 0);
        wb_valid = 0; exit_valid = 0;
        if (nb > 0 && $urandom_range(0, 1) == 1) begin
            wb_valid   = 1;
            wb_warp_id = 3'(busy_list[$urandom_range(0, nb - 1)]);
        end else if ($urandom_range(0, 7) == 0) begin
            wb_valid   = 1;
            wb_warp_id = 3'($urandom_range(0, 7));
        end
        if (nb > 0 && $urandom_range(0, 4) == 0) begin
            exit_valid   = 1;
            exit_warp_id = 3'(busy_list[$urandom_range(0, nb - 1)]);
            if (wb_valid && $urandom_range(0, 2) == 0) exit_warp_id = wb_warp_id;
        end else if ($urandom_range(0, 15) == 0) begin
            exit_valid   = 1;
            exit_warp_id = 3'($urandom_range(0, 7));
        end
        start     = ($urandom_range(0, 7) == 0);
        block_id  = $urandom;
        block_dim = $urandom_range(0, 400);
    endtask

    task automatic run_block(input logic [31:0] dim, input int stall, input int rst_at);
        int cyc;
        quiet_inputs();
        start     = 1;
        block_id  = $urandom;
        block_dim = dim;
        step();
        cyc = 0;
        while (m_phase != 0 && cyc < 3000) begin
            if (cyc < stall + 2)
                quiet_inputs();
            else
                rand_inputs();
            if (rst_at > 0 && cyc == rst_at) rst = 1;
            step();
            rst = 0;
            cyc++;
        end
        chk("block_cycle_budget", cyc < 3000, 1'b1);
    endtask

    initial begin
        quiet_inputs();
        rst = 1;
        step();
        step();
        rst = 0;
        step();
        run_block(32'd70, 5, 0);
        run_block(32'd0, 0, 0);
        run_block(32'd300, 1, 0);
        run_block(32'd256, 0, 0);
        run_block(32'd1, 0, 0);
        run_block(32'd32, 2, 0);
        run_block(32'd33, 0, 0);
        run_block(32'hFFFF_FFF0, 0, 0);
        run_block(32'd256, 0, 10);
        run_block(32'd70, 0, 0);
        for (int b = 0; b < 25; b++)
            run_block(32'($urandom_range(0, 300)), $urandom_range(0, 6), 0);
        quiet_inputs();
        step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
